// File: rtl/fifo_stream_reader.sv
// Read-side engine for a 16-entry registered-output FIFO: pops a programmed
// number of words and streams them out through a 2-entry skid buffer.
module fifo_stream_reader #(
  parameter int DW    = 32,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             fifo_rd_en,
  input  logic             fifo_empty,
  input  logic [DW-1:0]    fifo_data,
  output logic [DW-1:0]    m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [LEN_W-1:0] issue_left;
  logic [LEN_W-1:0] out_left;
  logic             inflight;
  logic [DW-1:0]    skid0;
  logic [DW-1:0]    skid1;
  logic [1:0]       occ;
  logic             pop;
  logic             capture;
  logic             accept;
  logic             drain_clear;

  // Slots that stay committed next cycle: held words plus the word in flight,
  // minus the one leaving on a handshake this cycle.
  function automatic logic [2:0] slots_used(input logic [1:0] held,
                                            input logic       fly,
                                            input logic       leave);
    return {1'b0, held} + {2'b00, fly} - {2'b00, leave};
  endfunction

  assign pop     = (occ != 2'd0) && m_ready;
  assign capture = inflight;
  assign accept  = (state == S_IDLE) && start;

  assign fifo_rd_en = (state == S_RUN) && (issue_left != '0) && !fifo_empty &&
                      (slots_used(occ, inflight, pop) < 3'd2);

  // The last word always leaves while in DRAIN, so finishing on that
  // handshake gives done in the very next cycle.
  assign drain_clear = !inflight &&
                       (((occ == 2'd0) && (out_left == '0)) ||
                        ((occ == 2'd1) && pop && (out_left == LEN_W'(1))));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (fifo_rd_en && (issue_left == LEN_W'(1))) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_clear) begin
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      issue_left <= '0;
      out_left   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        issue_left <= len;
        out_left   <= len;
      end else begin
        if (fifo_rd_en) begin
          issue_left <= issue_left - LEN_W'(1);
        end
        if (pop && (out_left != '0)) begin
          out_left <= out_left - LEN_W'(1);
        end
      end
    end
  end

  // Stage p0 -> p1: pop issued, FIFO presents the word one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
    end
  end

  // Stage p1 -> p2: capture into the skid buffer; head entry drives the stream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid0 <= '0;
      skid1 <= '0;
      occ   <= 2'd0;
    end else begin
      case ({capture, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            skid0 <= fifo_data;
          end else begin
            skid1 <= fifo_data;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          skid0 <= skid1;
          occ   <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            skid0 <= fifo_data;
          end else begin
            skid0 <= skid1;
            skid1 <= fifo_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign m_data  = skid0;
  assign m_valid = (occ != 2'd0);
  assign m_last  = m_valid && (out_left == LEN_W'(1));
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO model, expected-word
// scoreboard, a table of full-rate transfers and hand-written corner cases.
module tb_fifo_stream_reader;
  localparam int DW    = 32;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] xfer_len;
  logic             busy;
  logic             done;
  logic             fifo_rd_en;
  logic             fifo_empty;
  logic [DW-1:0]    fifo_data;
  logic [DW-1:0]    m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;

  always #5 clk = ~clk;

  fifo_stream_reader #(.DW(DW), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(xfer_len), .busy(busy),
    .done(done), .fifo_rd_en(fifo_rd_en), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last)
  );

  // Synchronous FIFO model with registered read data
  logic          push_req;
  logic [DW-1:0] push_val;
  logic [DW-1:0] fq[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fq.delete();
      fifo_data  <= '0;
      fifo_empty <= 1'b1;
    end else begin
      if (fifo_rd_en && (fq.size() != 0)) fifo_data <= fq.pop_front();
      if (push_req) fq.push_back(push_val);
      fifo_empty <= (fq.size() == 0);
    end
  end

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    int            len;
    int            lat;
    logic [DW-1:0] base;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0, done_cnt = 0, hs_cnt = 0;
  int r0, d0, h0;
  int xfer_cyc = 0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: observe at the falling edge, return 1 time unit after the rising edge
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      if (fifo_rd_en) begin
        rd_cnt++;
        chk("rd_en_while_empty", fifo_empty, 0);
      end
      if (done) done_cnt++;
      if (stall_prev) begin
        chk("hold_data", m_data, prev_data);
        chk("hold_last", m_last, prev_last);
      end
      if (m_valid && m_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_word", m_data, 64'hDEAD_0000);
        end else begin
          e = exp_q.pop_front();
          chk("m_data", m_data, e.data);
          chk("m_last", m_last, e.last);
        end
      end
      stall_prev = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
    @(posedge clk);
    #1;
    xfer_cyc++;
  endtask

  task automatic preload(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      push_req = 1'b1;
      push_val = base + DW'(i);
      exp_q.push_back('{data: base + DW'(i), last: (i == n - 1)});
      step();
    end
    push_req = 1'b0;
  endtask

  task automatic start_xfer(input int l);
    r0 = rd_cnt;
    d0 = done_cnt;
    h0 = hs_cnt;
    xfer_len = l[LEN_W-1:0];
    start    = 1'b1;
    xfer_cyc = 0;
    step();
    start    = 1'b0;
    xfer_len = '0;
  endtask

  task automatic wait_done(input int l, input int lat);
    while (!done && xfer_cyc < 300) step();
    chk("done_seen", done, 1);
    if (lat >= 0) chk("done_latency", xfer_cyc, lat);
    step();
    chk("done_pulse_width", done, 0);
    chk("busy_after_done", busy, 0);
    chk("pop_count", rd_cnt - r0, l);
    chk("done_count", done_cnt - d0, 1);
    chk("word_count", hs_cnt - h0, l);
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  initial begin
    vec_t vt[6];
    int   hs_cyc[$];
    int   exp_hs[3];

    vt[0] = '{len: 4,  lat: 7,  base: 32'h0000_00A0};
    vt[1] = '{len: 1,  lat: 4,  base: 32'h0000_0010};
    vt[2] = '{len: 2,  lat: 5,  base: 32'h0000_0020};
    vt[3] = '{len: 7,  lat: 10, base: 32'h0000_0030};
    vt[4] = '{len: 16, lat: 19, base: 32'h0000_0100};
    vt[5] = '{len: 0,  lat: 1,  base: 32'h0000_0000};
    exp_hs = '{8, 12, 13};

    rst = 1'b1; start = 1'b0; xfer_len = '0; m_ready = 1'b1;
    push_req = 1'b0; push_val = '0;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_rd_en", fifo_rd_en, 0);
    chk("reset_m_valid", m_valid, 0);
    chk("reset_m_last", m_last, 0);
    chk("reset_m_data", m_data, 0);
    @(posedge clk); #1;
    step();
    rst = 1'b0;
    step();

    // Full-rate transfers, including the A0..A3 case and len=0
    for (int v = 0; v < 6; v++) begin
      m_ready = 1'b1;
      preload(vt[v].base, vt[v].len);
      start_xfer(vt[v].len);
      wait_done(vt[v].len, vt[v].lat);
    end

    // Downstream stall: only two pops outstanding, head word held
    m_ready = 1'b0;
    preload(32'h0000_00B0, 8);
    start_xfer(8);
    repeat (9) step();
    chk("stall_pops", rd_cnt - r0, 2);
    chk("stall_valid", m_valid, 1);
    chk("stall_data", m_data, 32'h0000_00B0);
    chk("stall_last", m_last, 0);
    m_ready = 1'b1;
    wait_done(8, -1);

    // Empty FIFO at start, words trickle in at cycles 5, 9 and 10
    m_ready = 1'b1;
    exp_q.push_back('{data: 32'h0000_00C0, last: 1'b0});
    exp_q.push_back('{data: 32'h0000_00C1, last: 1'b0});
    exp_q.push_back('{data: 32'h0000_00C2, last: 1'b1});
    start_xfer(3);
    for (int c = 2; c <= 40; c++) begin
      push_req = (xfer_cyc == 5) || (xfer_cyc == 9) || (xfer_cyc == 10);
      push_val = (xfer_cyc == 5) ? 32'h0000_00C0 :
                 (xfer_cyc == 9) ? 32'h0000_00C1 : 32'h0000_00C2;
      if (m_valid && m_ready) hs_cyc.push_back(xfer_cyc);
      if (done) break;
      step();
    end
    push_req = 1'b0;
    chk("trickle_words", hs_cyc.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < hs_cyc.size()) chk("trickle_cycle", hs_cyc[i], exp_hs[i]);
    end
    wait_done(3, 14);

    // Asynchronous reset after two handshakes, then a fresh transfer
    m_ready = 1'b1;
    preload(32'h0000_00D0, 5);
    start_xfer(5);
    while ((hs_cnt - h0 < 2) && (xfer_cyc < 50)) step();
    chk("pre_reset_handshakes", hs_cnt - h0, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    chk("async_rd_en", fifo_rd_en, 0);
    chk("async_m_valid", m_valid, 0);
    chk("async_m_last", m_last, 0);
    chk("async_m_data", m_data, 0);
    exp_q.delete();
    stall_prev = 1'b0;
    step();
    rst = 1'b0;
    step();
    preload(32'h0000_00E0, 3);
    start_xfer(3);
    wait_done(3, 6);

    // A second start during a transfer is ignored
    m_ready = 1'b1;
    preload(32'h0000_00F0, 4);
    start_xfer(4);
    step();
    start    = 1'b1;
    xfer_len = LEN_W'(7);
    step();
    start    = 1'b0;
    xfer_len = '0;
    wait_done(4, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
